// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: per-stage destination records.
// A bubble is an all-zero record.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } stage_t;

  localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Sticks at all-ones once full.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Hazard and stage-tracking controller for the 5-stage core.
// Shadows EX/MEM/WB destinations and issues stall/bubble/flush.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs0,
  input  logic [4:0]       id_rs1,
  input  logic             id_uses_rs0,
  input  logic             id_uses_rs1,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             freeze_back,
  output logic [4:0]       ex_rd,
  output logic             ex_regwrite,
  output logic [4:0]       mem_rd,
  output logic             mem_regwrite,
  output logic [4:0]       wb_rd,
  output logic             wb_regwrite,
  output logic [CNT_W-1:0] stall_count
);

  stage_t ex_q, mem_q, wb_q;
  stage_t id_rec;
  logic   mem_wait, load_use;
  logic   rs0_hit, rs1_hit;

  assign mem_wait = mem_busy & mem_q.valid
                  & (mem_q.memread | mem_q.memwrite);

  assign rs0_hit = id_uses_rs0 & (id_rs0 == ex_q.rd);
  assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_q.rd);

  assign load_use = id_valid & ex_q.valid & ex_q.memread
                  & ex_q.regwrite & (ex_q.rd != 5'd0)
                  & (rs0_hit | rs1_hit);

  // Priority order matters: several terms may be true together.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    freeze_back = 1'b0;
    priority case (1'b1)
      mem_wait: begin
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        freeze_back = 1'b1;
      end
      ex_branch_taken: begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      load_use: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    id_rec = BUBBLE;
    if (id_valid && !ex_branch_taken && !load_use) begin
      id_rec.valid    = 1'b1;
      id_rec.rd       = id_rd;
      id_rec.regwrite = id_regwrite;
      id_rec.memread  = id_memread;
      id_rec.memwrite = id_memwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (!mem_wait) begin
      ex_q  <= id_rec;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_rd        = ex_q.valid ? ex_q.rd : 5'd0;
  assign ex_regwrite  = ex_q.valid & ex_q.regwrite;
  assign mem_rd       = mem_q.valid ? mem_q.rd : 5'd0;
  assign mem_regwrite = mem_q.valid & mem_q.regwrite;
  assign wb_rd        = wb_q.valid ? wb_q.rd : 5'd0;
  assign wb_regwrite  = wb_q.valid & wb_q.regwrite;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (mem_wait | load_use),
    .count(stall_count)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Directed self-checking bench for hazard_control.
// A second CNT_W=4 instance shares stimulus to exercise saturation.
module tb_hazard_control;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs0, id_rs1, id_rd;
  logic       id_uses_rs0, id_uses_rs1;
  logic       id_regwrite, id_memread, id_memwrite;
  logic       ex_branch_taken, mem_busy;

  logic        stall_if, stall_id, bubble_ex, flush_id, freeze_back;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_regwrite, mem_regwrite, wb_regwrite;
  logic [31:0] stall_count;

  logic        s4_if, s4_id, b4_ex, f4_id, fz4;
  logic [4:0]  ex4_rd, mem4_rd, wb4_rd;
  logic        ex4_rw, mem4_rw, wb4_rw;
  logic [3:0]  count4;

  logic [4:0]  ctl;
  int          checks;
  int          failures;

  assign ctl = {stall_if, stall_id, bubble_ex, flush_id, freeze_back};

  hazard_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs0(id_rs0), .id_rs1(id_rs1),
    .id_uses_rs0(id_uses_rs0), .id_uses_rs1(id_uses_rs1),
    .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .freeze_back(freeze_back),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .stall_count(stall_count)
  );

  hazard_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs0(id_rs0), .id_rs1(id_rs1),
    .id_uses_rs0(id_uses_rs0), .id_uses_rs1(id_uses_rs1),
    .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall_if(s4_if), .stall_id(s4_id), .bubble_ex(b4_ex),
    .flush_id(f4_id), .freeze_back(fz4),
    .ex_rd(ex4_rd), .ex_regwrite(ex4_rw),
    .mem_rd(mem4_rd), .mem_regwrite(mem4_rw),
    .wb_rd(wb4_rd), .wb_regwrite(wb4_rw),
    .stall_count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(
    input logic       v,
    input logic [4:0] rs0,
    input logic       u0,
    input logic [4:0] rs1,
    input logic       u1,
    input logic [4:0] rd,
    input logic       rw,
    input logic       mr
  );
    id_valid    = v;
    id_rs0      = rs0;
    id_uses_rs0 = u0;
    id_rs1      = rs1;
    id_uses_rs1 = u1;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_memwrite = 1'b0;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    checks++;
    if (ctl !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b0);
    end
    checks++;
    if ({ex_regwrite, mem_regwrite, wb_regwrite} !== 3'b0) begin
      failures++;
      $display("FAIL reset_rw got=%b exp=000",
               {ex_regwrite, mem_regwrite, wb_regwrite});
    end
    checks++;
    if ({ex_rd, mem_rd, wb_rd} !== 15'd0) begin
      failures++;
      $display("FAIL reset_rd got=%h exp=0", {ex_rd, mem_rd, wb_rd});
    end
    checks++;
    if (stall_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", stall_count);
    end
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    checks++;
    if ({ex_rd, ex_regwrite} !== {5'd5, 1'b1}) begin
      failures++;
      $display("FAIL lu_ex_lw got=%0d/%b exp=5/1", ex_rd, ex_regwrite);
    end
    drive_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctl !== 5'b11100) begin
      failures++;
      $display("FAIL lu_stall got=%b exp=11100", ctl);
    end
    step();
    checks++;
    if (ctl !== 5'b0) begin
      failures++;
      $display("FAIL lu_one_cycle got=%b exp=00000", ctl);
    end
    checks++;
    if ({ex_regwrite, mem_rd, mem_regwrite} !== {1'b0, 5'd5, 1'b1}) begin
      failures++;
      $display("FAIL lu_after got ex_rw=%b mem_rd=%0d exp 0/5",
               ex_regwrite, mem_rd);
    end
    checks++;
    if (stall_count !== 32'd1) begin
      failures++;
      $display("FAIL lu_count got=%0d exp=1", stall_count);
    end
    step();
    checks++;
    if ({ex_rd, wb_rd} !== {5'd6, 5'd5}) begin
      failures++;
      $display("FAIL lu_resume got ex=%0d wb=%0d exp 6/5", ex_rd, wb_rd);
    end
    drain();
  endtask

  task automatic test_no_hazard();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    checks++;
    if (ctl !== 5'b0) begin
      failures++;
      $display("FAIL nh_x0 got=%b exp=00000", ctl);
    end
    step();
    drive_id(1'b1, 5'd5, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctl !== 5'b0) begin
      failures++;
      $display("FAIL nh_unused got=%b exp=00000", ctl);
    end
    step();
    checks++;
    if (stall_count !== 32'd1) begin
      failures++;
      $display("FAIL nh_count got=%0d exp=1", stall_count);
    end
    drain();
  endtask

  task automatic test_mem_wait();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 5'b11001) begin
        failures++;
        $display("FAIL mw_ctl[%0d] got=%b exp=11001", i, ctl);
      end
      checks++;
      if ({ex_rd, mem_rd, wb_rd} !== {5'd8, 5'd7, 5'd9}) begin
        failures++;
        $display("FAIL mw_hold[%0d] got=%0d/%0d/%0d exp=8/7/9",
                 i, ex_rd, mem_rd, wb_rd);
      end
      step();
    end
    checks++;
    if (stall_count !== 32'd4) begin
      failures++;
      $display("FAIL mw_count got=%0d exp=4", stall_count);
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b0) begin
      failures++;
      $display("FAIL mw_release got=%b exp=00000", ctl);
    end
    step();
    checks++;
    if ({ex_rd, mem_rd, wb_rd, wb_regwrite} !==
        {5'd10, 5'd8, 5'd7, 1'b1}) begin
      failures++;
      $display("FAIL mw_advance got=%0d/%0d/%0d exp=10/8/7",
               ex_rd, mem_rd, wb_rd);
    end
    drain();
  endtask

  task automatic test_branch_load_use();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== 5'b00110) begin
      failures++;
      $display("FAIL br_ctl got=%b exp=00110", ctl);
    end
    step();
    ex_branch_taken = 1'b0;
    idle();
    #1;
    checks++;
    if ({ex_regwrite, mem_rd} !== {1'b0, 5'd5}) begin
      failures++;
      $display("FAIL br_squash got ex_rw=%b mem_rd=%0d exp 0/5",
               ex_regwrite, mem_rd);
    end
    checks++;
    if (stall_count !== 32'd5) begin
      failures++;
      $display("FAIL br_count got=%0d exp=5", stall_count);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    step();
    mem_busy = 1'b1;
    #1;
    checks++;
    if (freeze_back !== 1'b1) begin
      failures++;
      $display("FAIL rs_pre_freeze got=%b exp=1", freeze_back);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (ctl !== 5'b0) begin
      failures++;
      $display("FAIL rs_ctl got=%b exp=00000", ctl);
    end
    checks++;
    if ({ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite}
        !== 18'd0) begin
      failures++;
      $display("FAIL rs_stages got=%0d/%0d/%0d exp=0/0/0",
               ex_rd, mem_rd, wb_rd);
    end
    checks++;
    if (stall_count !== 32'd0) begin
      failures++;
      $display("FAIL rs_count got=%0d exp=0", stall_count);
    end
    rst_n = 1'b1;
    idle();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    checks++;
    if ({ex_rd, ex_regwrite} !== {5'd3, 1'b1}) begin
      failures++;
      $display("FAIL rs_issue got=%0d/%b exp=3/1", ex_rd, ex_regwrite);
    end
    idle();
    step();
    checks++;
    if ({mem_rd, mem_regwrite} !== {5'd3, 1'b1}) begin
      failures++;
      $display("FAIL rs_track got=%0d/%b exp=3/1", mem_rd, mem_regwrite);
    end
    drain();
  endtask

  task automatic test_saturate();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    step();
    idle();
    mem_busy = 1'b1;
    repeat (20) step();
    checks++;
    if (count4 !== 4'd15) begin
      failures++;
      $display("FAIL sat_count4 got=%0d exp=15", count4);
    end
    checks++;
    if (stall_count !== 32'd20) begin
      failures++;
      $display("FAIL sat_count32 got=%0d exp=20", stall_count);
    end
    step();
    checks++;
    if (count4 !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold got=%0d exp=15", count4);
    end
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_branch_load_use();
    test_reset_mid_stall();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
